// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/flush controller: state encoding,
// the zero-register index and the default performance-counter width.
package pipeline_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam logic [4:0]  REG_ZERO      = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the load in ID/EX writes a register that the
// instruction in IF/ID reads. Register zero never carries a dependency.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rt_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    output logic       lu_o
);

    assign lu_o = idex_memread_i && (idex_rt_i != REG_ZERO) &&
                  ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control FSM: load-use stalls, taken-branch flushes, front-end halt,
// plus saturating stall/flush performance counters.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rt,
    input  logic             PCSrc,
    input  logic             halt_req,
    input  logic             resume,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IDEX_bubble,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             EXMEM_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             lu;
    logic             stall_inc, flush_inc;

    load_use_detect u_lu (
        .idex_memread_i (IDEX_MemRead),
        .idex_rt_i      (IDEX_rt),
        .ifid_rs_i      (IFID_rs),
        .ifid_rt_i      (IFID_rt),
        .lu_o           (lu)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        IDEX_bubble = 1'b0;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        EXMEM_flush = 1'b0;
        flush_inc   = 1'b0;
        stall_inc   = 1'b0;
        if (reset) begin
            // Outputs track reset combinationally so the pipe is cleared at once.
            state_d     = RUN;
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (PCSrc) begin
                        IFID_flush  = 1'b1;
                        IDEX_flush  = 1'b1;
                        EXMEM_flush = 1'b1;
                        flush_inc   = 1'b1;
                        state_d     = FLUSH;
                    end else if (lu) begin
                        PC_write    = 1'b0;
                        IFID_write  = 1'b0;
                        IDEX_bubble = 1'b1;
                    end else if (halt_req) begin
                        state_d = HALT;
                    end
                end
                FLUSH: state_d = RUN;
                HALT: begin
                    PC_write    = 1'b0;
                    IFID_write  = 1'b0;
                    IDEX_bubble = 1'b1;
                    if (resume) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
            stall_inc = ~PC_write;
        end
    end

    assign state       = state_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl against a rule-level reference model;
// a second instance with 4-bit counters exercises saturation.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] IFID_rs, IFID_rt, IDEX_rt;
    logic       IDEX_MemRead, PCSrc, halt_req, resume;

    logic        a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf;
    logic [1:0]  a_state;
    logic [15:0] a_stall, a_flush;
    logic        b_pcw, b_ifw, b_bub, b_iff, b_idf, b_exf;
    logic [1:0]  b_state;
    logic [3:0]  b_stall, b_flush;

    pipeline_ctrl dut (
        .clk(clk), .reset(reset), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt), .PCSrc(PCSrc),
        .halt_req(halt_req), .resume(resume),
        .PC_write(a_pcw), .IFID_write(a_ifw), .IDEX_bubble(a_bub),
        .IFID_flush(a_iff), .IDEX_flush(a_idf), .EXMEM_flush(a_exf),
        .state(a_state), .stall_count(a_stall), .flush_count(a_flush)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt), .PCSrc(PCSrc),
        .halt_req(halt_req), .resume(resume),
        .PC_write(b_pcw), .IFID_write(b_ifw), .IDEX_bubble(b_bub),
        .IFID_flush(b_iff), .IDEX_flush(b_idf), .EXMEM_flush(b_exf),
        .state(b_state), .stall_count(b_stall), .flush_count(b_flush)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: mode 0 = running, 1 = one-cycle flush recovery, 2 = halted.
    int m_mode = 0;
    int m_stall16 = 0, m_stall4 = 0, m_flush16 = 0, m_flush4 = 0;

    // Check current-cycle outputs, then advance the model across the next edge.
    task automatic step();
        bit lu, pcw, ifw, bub, fl;
        logic [5:0] exp_v;
        #1;
        lu = IDEX_MemRead && IDEX_rt != 0 && (IDEX_rt == IFID_rs || IDEX_rt == IFID_rt);
        if (reset) begin
            m_mode = 0; m_stall16 = 0; m_stall4 = 0; m_flush16 = 0; m_flush4 = 0;
            pcw = 0; ifw = 0; bub = 0; fl = 1;
        end else if (m_mode == 2)            begin pcw = 0; ifw = 0; bub = 1; fl = 0; end
        else if (m_mode == 0 && PCSrc)       begin pcw = 1; ifw = 1; bub = 0; fl = 1; end
        else if (m_mode == 0 && lu)          begin pcw = 0; ifw = 0; bub = 1; fl = 0; end
        else                                 begin pcw = 1; ifw = 1; bub = 0; fl = 0; end
        exp_v = {pcw, ifw, bub, fl, fl, fl};
        check("ctl16",   {a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf}, exp_v);
        check("ctl4",    {b_pcw, b_ifw, b_bub, b_iff, b_idf, b_exf}, exp_v);
        check("state16", a_state, m_mode);
        check("state4",  b_state, m_mode);
        check("stall16", a_stall, m_stall16);
        check("stall4",  b_stall, m_stall4);
        check("flush16", a_flush, m_flush16);
        check("flush4",  b_flush, m_flush4);
        @(posedge clk);
        if (!reset) begin
            if (!pcw) begin
                if (m_stall16 < 65535) m_stall16++;
                if (m_stall4 < 15) m_stall4++;
            end
            if (m_mode == 0 && PCSrc) begin
                if (m_flush16 < 65535) m_flush16++;
                if (m_flush4 < 15) m_flush4++;
                m_mode = 1;
            end else if (m_mode == 0 && !lu && halt_req) m_mode = 2;
            else if (m_mode == 1) m_mode = 0;
            else if (m_mode == 2 && resume) m_mode = 0;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit mr, input int rt, input int rs, input int rt2,
                         input bit pcs, input bit hr, input bit res, input bit rst);
        IDEX_MemRead = mr; IDEX_rt = rt[4:0]; IFID_rs = rs[4:0]; IFID_rt = rt2[4:0];
        PCSrc = pcs; halt_req = hr; resume = res; reset = rst;
        step();
    endtask

    int s0;

    initial begin
        reset = 1'b1; IDEX_MemRead = 0; IDEX_rt = 0; IFID_rs = 0; IFID_rt = 0;
        PCSrc = 0; halt_req = 0; resume = 0;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Load-use on rs: one-cycle stall
        drive(1, 8, 8, 3, 0, 0, 0, 0);
        #1 check("lu_stall_cnt", a_stall, 1);
        // rt = 0 never hazards
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        // Branch beats load-use; flush then back to running
        drive(1, 9, 1, 9, 1, 0, 0, 0);
        #1 check("br_state_flush", a_state, 1);
        drive(1, 9, 1, 9, 1, 1, 0, 0);
        #1 check("br_state_run", a_state, 0);
        check("br_flush_cnt", a_flush, 1);

        // Halt for four cycles with a branch pulse that must be ignored
        s0 = int'(a_stall);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        #1 check("halt_stalls", a_stall, s0 + 4);
        check("halt_flush_cnt", a_flush, 1);

        // Reset while halted clears everything asynchronously
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1; #1;
        check("async_state", a_state, 0);
        check("async_stall", a_stall, 0);
        check("async_flush", {a_iff, a_idf, a_exf}, 3'b111);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Twenty halted cycles saturate the 4-bit counter
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        repeat (20) drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("sat4_stall", b_stall, 15);
        check("sat16_stall", a_stall, 20);
        drive(0, 0, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(1, 0) == 1, $urandom_range(3, 0), $urandom_range(3, 0),
                  $urandom_range(3, 0), $urandom_range(6, 0) == 0, $urandom_range(9, 0) == 0,
                  $urandom_range(3, 0) == 0, $urandom_range(99, 0) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall and flush performance counters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 IFID_rs  input  5  rs field of the instruction in IF/ID.
REQ-005 IFID_rt  input  5  rt field of the instruction in IF/ID.
REQ-006 IDEX_MemRead  input  1  ID/EX instruction is a load.
REQ-007 IDEX_rt  input  5  destination rt of the ID/EX load.
REQ-008 PCSrc  input  1  taken branch resolved in MEM; the PC loads the EX/MEM target.
REQ-009 halt_req  input  1  request to freeze the front end.
REQ-010 resume  input  1  release from HALT.
REQ-011 PC_write  output  1  PC update enable.
REQ-012 IFID_write  output  1  IF/ID latch enable.
REQ-013 IDEX_bubble  output  1  zero the control fields loaded into ID/EX (WB, Mem, EX).
REQ-014 IFID_flush, IDEX_flush, EXMEM_flush  output  1 each  clear the respective latch.
REQ-015 state  output  2  current FSM state.
REQ-016 stall_count, flush_count  output  CNT_W each  performance counters.

Function
REQ-017 FSM states: RUN=0, FLUSH=1, HALT=2; encoding 3 is illegal and SHALL return to RUN on the next edge.
REQ-018 Load-use hazard (lu) = IDEX_MemRead && IDEX_rt!=0 && (IDEX_rt==IFID_rs || IDEX_rt==IFID_rt).
REQ-019 Control outputs SHALL be combinational from state and the current inputs (zero latency); state and counters SHALL be registered.
REQ-020 In RUN, priority is PCSrc > lu > halt_req.
REQ-021 RUN with PCSrc:
 - PC_write=1, IFID_write=1.
 - IFID_flush, IDEX_flush and EXMEM_flush all =1; IDEX_bubble=0.
 - Next state FLUSH; flush_count increments.
REQ-022 RUN with lu and no PCSrc:
 - PC_write=0, IFID_write=0, IDEX_bubble=1.
 - Remain in RUN; the stall lasts exactly one cycle, because the bubble clears IDEX_MemRead.
REQ-023 RUN with halt_req, no PCSrc and no lu: this cycle behaves as normal RUN; next state HALT.
REQ-024 RUN with no event: PC_write=1, IFID_write=1, all flushes and IDEX_bubble =0.
REQ-025 FLUSH lasts one cycle:
 - lu, PCSrc and halt_req are ignored.
 - Outputs are as in normal RUN; next state RUN.
REQ-026 HALT:
 - PC_write=0, IFID_write=0, IDEX_bubble=1.
 - PCSrc is ignored.
 - resume=1 returns to RUN on the next edge; halt_req and resume both high SHALL also resume.
REQ-027 stall_count SHALL increment in every non-reset cycle with PC_write=0, saturating at 2^CNT_W-1.
REQ-028 flush_count SHALL increment once per accepted PCSrc and SHALL saturate at 2^CNT_W-1.

Reset
REQ-029 While reset is high:
 - state=RUN, stall_count=0, flush_count=0.
 - PC_write=0, IFID_write=0, IDEX_bubble=0.
 - IFID_flush, IDEX_flush and EXMEM_flush all =1.
REQ-030 Reset asserted mid-stall, mid-FLUSH or in HALT SHALL abandon that state immediately; the first cycle after deassertion is normal RUN.

Structure
REQ-031 Shared package pipeline_pkg SHALL hold:
 - the state encoding constants (RUN, FLUSH, HALT);
 - REG_ZERO=5'd0;
 - default CNT_W.
REQ-032 The lu compare SHALL live in one combinational sub-module, load_use_detect, reused by pipeline_ctrl.

Verification
REQ-033 IDEX_MemRead=1, IDEX_rt=8, IFID_rs=8 -> same cycle PC_write=0, IFID_write=0, IDEX_bubble=1; stall_count=1 after the edge.
REQ-034 IDEX_MemRead=1, IDEX_rt=0, IFID_rs=0 -> no stall; PC_write=1.
REQ-035 PCSrc=1 concurrent with lu (rt=9 matches IFID_rt=9) -> three flushes =1, PC_write=1; state=FLUSH next cycle, then RUN; flush_count=1.
REQ-036 halt_req=1 for 1 cycle, resume after 4 cycles -> HALT entered next edge; stall_count=4 on release; PCSrc pulse during HALT has no effect.
REQ-037 reset asserted while in HALT -> state=0, counters=0, flushes=1 asynchronously; RUN resumes after deassertion.
REQ-038 CNT_W=4, 20 stall cycles -> stall_count holds at 15.
